// File: rtl/fp16_pkg.sv
// Shared FP16/INT4 constants and result type, used by both the quantize and dequantize paths.
package fp16_pkg;
    localparam int FP16_W    = 16;
    localparam int EXP_W     = 5;
    localparam int MANT_W    = 10;
    localparam int EXP_BIAS  = 15;
    localparam int INT4_W    = 4;

    localparam logic [3:0]  INT4_MAX     = 4'd15;
    localparam logic [4:0]  EXP_SPECIAL  = 5'd31;
    localparam logic [15:0] FP16_POS_INF = 16'h7C00;
    localparam logic [15:0] FP16_NEG_INF = 16'hFC00;
    localparam logic [15:0] FP16_QNAN    = 16'h7E00;

    typedef struct packed {
        logic [3:0] int4;
        logic       sat;
        logic       neg;
        logic       nan;
    } q_result_t;
endpackage

// File: rtl/fp16_to_int4_round.sv
// Combinational FP16 -> unsigned INT4 conversion: round half-to-even, clamp to 0..15,
// flagging saturation, negative clamping and NaN.
module fp16_to_int4_round
    import fp16_pkg::*;
(
    input  logic [15:0] fp_in,
    output q_result_t   res
);

    logic        sign_s;
    logic [4:0]  exp_s;
    logic [9:0]  mant_s;
    logic [4:0]  shamt_s;
    logic [21:0] ext_s;
    logic        up_s;
    logic [11:0] rnd_s;

    // Classify the input, then align the significand so bits [21:11] hold the integer part.
    always_comb begin
        sign_s  = fp_in[15];
        exp_s   = fp_in[14:10];
        mant_s  = fp_in[9:0];
        res     = '0;
        shamt_s = 5'd0;
        ext_s   = 22'd0;
        up_s    = 1'b0;
        rnd_s   = 12'd0;
        if ((exp_s == EXP_SPECIAL) && (mant_s != 10'd0)) begin
            res.nan = 1'b1;
        end else if (sign_s) begin
            res.neg = 1'b1;
        end else if (exp_s == EXP_SPECIAL) begin
            res.int4 = INT4_MAX;
            res.sat  = 1'b1;
        end else if (exp_s < 5'(EXP_BIAS - 1)) begin
            res.int4 = 4'd0;
        end else if (exp_s > 5'(EXP_BIAS + 3)) begin
            res.int4 = INT4_MAX;
            res.sat  = 1'b1;
        end else begin
            // Shift by 10-E where E = exp-15, i.e. 25-exp (7..11 here)
            shamt_s = 5'd25 - exp_s;
            ext_s   = {1'b1, mant_s, 11'd0} >> shamt_s;
            up_s    = ext_s[10] & ((|ext_s[9:0]) | ext_s[11]);
            rnd_s   = {1'b0, ext_s[21:11]} + {11'd0, up_s};
            if (rnd_s > 12'd15) begin
                res.int4 = INT4_MAX;
                res.sat  = 1'b1;
            end else begin
                res.int4 = rnd_s[3:0];
            end
        end
    end

endmodule

// File: rtl/fp16_to_int4_packer.sv
// Streaming FP16 -> INT4 quantizer that packs PACK_N nibbles per output word.
// Optional status counters are built when FP16_Q_STATUS_EN is defined.
module fp16_to_int4_packer
    import fp16_pkg::*;
#(
    parameter int PACK_N = 4,
    parameter int OUT_W  = 4 * PACK_N
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [15:0]                 in_data,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OUT_W-1:0]            out_data,
    output logic [$clog2(PACK_N):0]     out_cnt,
`ifdef FP16_Q_STATUS_EN
    input  logic                        stat_clr,
    output logic [15:0]                 sat_cnt,
    output logic [15:0]                 neg_cnt,
    output logic [15:0]                 nan_cnt,
`endif
    output logic                        out_last
);

    localparam int IDX_W = $clog2(PACK_N);
    localparam int CNT_W = IDX_W + 1;

    q_result_t          conv_s;
    logic               complete_possible_s;
    logic               hs_s;
    logic               load_s;
    logic [OUT_W-1:0]   acc_wr_s;

    logic [OUT_W-1:0]   acc_q, acc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic               out_last_q, out_last_d;
    logic               out_valid_q, out_valid_d;

    fp16_to_int4_round u_round (
        .fp_in (in_data),
        .res   (conv_s)
    );

    // A completing sample may only enter when the output register is free or draining.
    assign complete_possible_s = (idx_q == IDX_W'(PACK_N - 1)) | in_last;
    assign in_ready  = ~(complete_possible_s & out_valid_q & ~out_ready);
    assign hs_s      = in_valid & in_ready;
    assign load_s    = hs_s & complete_possible_s;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_cnt   = out_cnt_q;
    assign out_last  = out_last_q;

    // Accumulator insertion, word hand-off and output-register drain.
    always_comb begin
        acc_wr_s                   = acc_q;
        acc_wr_s[{idx_q, 2'b00} +: 4] = conv_s.int4;
        acc_d       = acc_q;
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        out_cnt_d   = out_cnt_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        if (load_s) begin
            out_data_d  = acc_wr_s;
            out_cnt_d   = {1'b0, idx_q} + CNT_W'(1'b1);
            out_last_d  = in_last;
            out_valid_d = 1'b1;
            acc_d       = '0;
            idx_d       = '0;
        end else if (hs_s) begin
            acc_d       = acc_wr_s;
            idx_d       = idx_q + IDX_W'(1'b1);
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end else begin
                out_valid_d = out_valid_q;
            end
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end else begin
                out_valid_d = out_valid_q;
            end
        end
    end

    // Packer and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_cnt_q   <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_cnt_q   <= out_cnt_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef FP16_Q_STATUS_EN
    logic [15:0] sat_cnt_q, sat_cnt_d;
    logic [15:0] neg_cnt_q, neg_cnt_d;
    logic [15:0] nan_cnt_q, nan_cnt_d;

    // Saturating event counters; clear has priority over a same-cycle increment.
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        neg_cnt_d = neg_cnt_q;
        nan_cnt_d = nan_cnt_q;
        if (stat_clr) begin
            sat_cnt_d = 16'd0;
            neg_cnt_d = 16'd0;
            nan_cnt_d = 16'd0;
        end else if (hs_s) begin
            if (conv_s.sat && (sat_cnt_q != 16'hFFFF)) sat_cnt_d = sat_cnt_q + 16'd1;
            else                                        sat_cnt_d = sat_cnt_q;
            if (conv_s.neg && (neg_cnt_q != 16'hFFFF)) neg_cnt_d = neg_cnt_q + 16'd1;
            else                                        neg_cnt_d = neg_cnt_q;
            if (conv_s.nan && (nan_cnt_q != 16'hFFFF)) nan_cnt_d = nan_cnt_q + 16'd1;
            else                                        nan_cnt_d = nan_cnt_q;
        end else begin
            sat_cnt_d = sat_cnt_q;
        end
    end

    // Status counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_cnt_q <= 16'd0;
            neg_cnt_q <= 16'd0;
            nan_cnt_q <= 16'd0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
            neg_cnt_q <= neg_cnt_d;
            nan_cnt_q <= nan_cnt_d;
        end
    end

    assign sat_cnt = sat_cnt_q;
    assign neg_cnt = neg_cnt_q;
    assign nan_cnt = nan_cnt_q;
`endif

endmodule

// File: tb/tb_fp16_to_int4_packer.sv
// Self-checking bench for fp16_to_int4_packer: real-valued conversion model plus a
// word-level packing/output-register model, with directed and randomized scenarios.
module tb_fp16_to_int4_packer;

    localparam int PACK_N = 4;
    localparam int OUT_W  = 4 * PACK_N;
    localparam int CNT_W  = $clog2(PACK_N) + 1;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic [CNT_W-1:0]  out_cnt;
    logic              out_last;
`ifdef FP16_Q_STATUS_EN
    logic              stat_clr;
    logic [15:0]       sat_cnt;
    logic [15:0]       neg_cnt;
    logic [15:0]       nan_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int               m_idx  = 0;
    logic [OUT_W-1:0] m_acc  = '0;
    logic             m_ov   = 1'b0;
    logic [OUT_W-1:0] m_data = '0;
    int               m_cnt  = 0;
    logic             m_last = 1'b0;
    int               n_acc  = 0;

    fp16_to_int4_packer #(.PACK_N(PACK_N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_cnt   (out_cnt),
`ifdef FP16_Q_STATUS_EN
        .stat_clr  (stat_clr),
        .sat_cnt   (sat_cnt),
        .neg_cnt   (neg_cnt),
        .nan_cnt   (nan_cnt),
`endif
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decode the FP16 value to a real, round half-to-even, clamp to 0..15.
    function automatic int ref_conv(input logic [15:0] h);
        int  e;
        int  m;
        int  r;
        real v;
        real f;
        real d;
        e = int'(h[14:10]);
        m = int'(h[9:0]);
        if (e == 31 && m != 0) return 0;
        if (h[15]) return 0;
        if (e == 31) return 15;
        if (e == 0) return 0;
        v = (1.0 + real'(m) / 1024.0) * (2.0 ** (e - 15));
        f = $floor(v);
        d = v - f;
        r = int'(f);
        if (d > 0.5 || (d == 0.5 && (r % 2) == 1)) r = r + 1;
        if (r > 15) r = 15;
        return r;
    endfunction

    // One clock cycle: drive, check DUT against the model, advance model, move to next negedge.
    task automatic cycle(input logic v, input logic [15:0] d, input logic l, input logic r);
        logic exp_rdy;
        logic hs;
        logic drain;
        logic load;
        int   nib;
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        #1;
        exp_rdy = !(((m_idx == PACK_N - 1) || l) && m_ov && !r);
        n_tests++;
        if (in_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL in_ready: got %b expected %b (idx=%0d last=%b)", in_ready, exp_rdy, m_idx, l);
        end
        n_tests++;
        if (out_valid !== m_ov) begin
            n_fail++;
            $display("FAIL out_valid: got %b expected %b", out_valid, m_ov);
        end
        if (m_ov) begin
            n_tests++;
            if (out_data !== m_data || out_cnt !== CNT_W'(m_cnt) || out_last !== m_last) begin
                n_fail++;
                $display("FAIL out_word: got %h/%0d/%b expected %h/%0d/%b",
                         out_data, out_cnt, out_last, m_data, m_cnt, m_last);
            end
        end
        drain = m_ov && r;
        hs    = v && exp_rdy;
        load  = 1'b0;
        if (hs) begin
            nib = ref_conv(d);
            m_acc[4*m_idx +: 4] = nib[3:0];
            m_idx++;
            n_acc++;
            if (m_idx == PACK_N || l) begin
                m_data = m_acc;
                m_cnt  = m_idx;
                m_last = l;
                m_acc  = '0;
                m_idx  = 0;
                load   = 1'b1;
            end
        end
        if (load) m_ov = 1'b1;
        else if (drain) m_ov = 1'b0;
        @(negedge clk);
    endtask

    // Spec-constant check of the word currently presented (no clock advance).
    task automatic expect_word(input logic [OUT_W-1:0] d, input int c, input logic l, input string name);
        #1;
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== d || out_cnt !== CNT_W'(c) || out_last !== l) begin
            n_fail++;
            $display("FAIL %s: got v=%b %h/%0d/%b expected v=1 %h/%0d/%b",
                     name, out_valid, out_data, out_cnt, out_last, d, c, l);
        end
    endtask

    task automatic drain_all();
        for (int i = 0; i < 20 && m_ov; i++) cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        n_tests++;
        if (m_ov) begin
            n_fail++;
            $display("FAIL drain_timeout: got pending=%b expected 0", m_ov);
        end
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_cnt !== '0 || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got %b %h %0d %b expected 0 0 0 0", out_valid, out_data, out_cnt, out_last);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_basic();
        cycle(1'b1, 16'h3C00, 1'b0, 1'b1);
        cycle(1'b1, 16'h4000, 1'b0, 1'b1);
        cycle(1'b1, 16'h4200, 1'b0, 1'b1);
        cycle(1'b1, 16'h4400, 1'b0, 1'b1);
        expect_word(16'h4321, 4, 1'b0, "basic_word");
        drain_all();
    endtask

    task automatic test_rounding();
        cycle(1'b1, 16'h3800, 1'b0, 1'b1);
        cycle(1'b1, 16'h3E00, 1'b0, 1'b1);
        cycle(1'b1, 16'h4100, 1'b0, 1'b1);
        cycle(1'b1, 16'h4980, 1'b0, 1'b1);
        expect_word(16'hB220, 4, 1'b0, "rounding_word");
        drain_all();
    endtask

    task automatic test_specials();
        cycle(1'b1, 16'h4BC0, 1'b0, 1'b1);
        cycle(1'b1, 16'h4F80, 1'b0, 1'b1);
        cycle(1'b1, 16'h7C00, 1'b0, 1'b1);
        cycle(1'b1, 16'hBC00, 1'b0, 1'b1);
        expect_word(16'h0FFF, 4, 1'b0, "specials_word");
        cycle(1'b1, 16'h7E00, 1'b1, 1'b1);
        expect_word(16'h0000, 1, 1'b1, "nan_single_last");
        drain_all();
`ifdef FP16_Q_STATUS_EN
        n_tests++;
        if (sat_cnt !== 16'd3 || neg_cnt !== 16'd1 || nan_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL status_cnt: got %0d/%0d/%0d expected 3/1/1", sat_cnt, neg_cnt, nan_cnt);
        end
`endif
    endtask

    task automatic test_partial();
        cycle(1'b1, 16'h3C00, 1'b0, 1'b1);
        cycle(1'b1, 16'h4000, 1'b0, 1'b1);
        cycle(1'b1, 16'h4200, 1'b1, 1'b1);
        expect_word(16'h0321, 3, 1'b1, "partial_flush");
        drain_all();
    endtask

    task automatic test_backpressure();
        int         start;
        logic [15:0] d;
        start = n_acc;
        for (int c = 0; c < 3000 && n_acc < start + 64; c++) begin
            if ($urandom_range(1, 0) == 1) d = 16'($urandom);
            else d = {1'b0, 5'($urandom_range(19, 13)), 10'($urandom)};
            cycle(1'($urandom_range(3, 0) != 0), d, 1'($urandom_range(7, 0) == 0),
                  1'($urandom_range(1, 0)));
        end
        n_tests++;
        if (n_acc < start + 64) begin
            n_fail++;
            $display("FAIL backpressure_budget: got %0d accepted expected 64", n_acc - start);
        end
        for (int i = 0; i < 20 && m_idx != 0; i++) cycle(1'b1, 16'h3C00, 1'b1, 1'b1);
        drain_all();
    endtask

    task automatic test_mid_reset();
        cycle(1'b1, 16'h3C00, 1'b0, 1'b0);
        cycle(1'b1, 16'h4000, 1'b0, 1'b0);
        cycle(1'b1, 16'h4200, 1'b0, 1'b0);
        cycle(1'b1, 16'h4400, 1'b0, 1'b0);
        cycle(1'b1, 16'h3C00, 1'b0, 1'b0);
        cycle(1'b1, 16'h4000, 1'b0, 1'b0);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_cnt !== '0 || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %b %h %0d %b expected 0 0 0 0", out_valid, out_data, out_cnt, out_last);
        end
`ifdef FP16_Q_STATUS_EN
        n_tests++;
        if (sat_cnt !== 16'd0 || neg_cnt !== 16'd0 || nan_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL midreset_status: got %0d/%0d/%0d expected 0/0/0", sat_cnt, neg_cnt, nan_cnt);
        end
`endif
        @(negedge clk);
        rst    = 1'b0;
        m_idx  = 0;
        m_acc  = '0;
        m_ov   = 1'b0;
        @(negedge clk);
        cycle(1'b1, 16'h4500, 1'b0, 1'b1);
        cycle(1'b1, 16'h4600, 1'b0, 1'b1);
        cycle(1'b1, 16'h4700, 1'b0, 1'b1);
        cycle(1'b1, 16'h4800, 1'b0, 1'b1);
        expect_word(16'h8765, 4, 1'b0, "post_reset_word");
        drain_all();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        in_last   = 1'b0;
        out_ready = 1'b0;
`ifdef FP16_Q_STATUS_EN
        stat_clr  = 1'b0;
`endif
        repeat (2) @(negedge clk);
        test_reset();
        test_basic();
        test_rounding();
        test_specials();
        test_partial();
        test_backpressure();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
